// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU emulator: FSM state encoding, parameter
// defaults and a saturating counter helper.
package tlu_pkg;

  // Handshake FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ASSERT  = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4
  } tlu_state_e;

  localparam int unsigned NBITS_DEF        = 16;
  localparam int unsigned SYNC_STAGES_DEF  = 2;
  localparam int unsigned BUSY_TIMEOUT_DEF = 4096;
  localparam int unsigned MIN_GAP_DEF      = 16;

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tlu_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous input.
// Ports:
//   clk   - sampling clock
//   rst   - synchronous active-high reset (clears the chain to 0)
//   din   - asynchronous input
//   level - synchronized level (last stage of the chain)
//   rise  - one-cycle pulse on a synchronized 0->1 transition
//   fall  - one-cycle pulse on a synchronized 1->0 transition
module tlu_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/tlu_emulator.sv
// Trigger Logic Unit emulator: TLU end of the trigger / busy / trigger-clock
// handshake. Issues a trigger on request or periodically, waits for the DUT
// to raise BUSY, then shifts the trigger number LSB-first on TRIGGER_OUT,
// one bit per falling edge of the DUT-driven trigger clock.
// Ports:
//   CLK              - emulator clock (at least 8x the trigger-clock rate)
//   RST_SYS          - synchronous active-high reset
//   EN               - enables trigger issue
//   TRIG_REQ         - single-cycle trigger request
//   PERIODIC_EN      - enables the internal periodic trigger generator
//   PERIOD           - periodic interval in CLK cycles (0 and 1 act as 2)
//   BUSY_IN          - DUT busy, asynchronous
//   TRIGGER_CLOCK_IN - DUT trigger clock, asynchronous
//   TRIGGER_OUT      - trigger / serial trigger-number line
//   TRIGGER_CNT      - number carried by the most recent trigger
//   TRIGGER_SENT     - pulse: all bits shifted and BUSY released
//   TIMEOUT_ERR      - pulse: BUSY failed to rise or to fall in time
//   SHORT_ERR        - pulse: BUSY fell before all bits were clocked out
//   REQ_DROPPED      - pulse: request arrived while a handshake was active
//   DROPPED_CNT      - saturating count of dropped requests
//   IDLE             - 1 while the FSM is idle
module tlu_emulator
  import tlu_pkg::*;
#(
  parameter int unsigned NBITS        = NBITS_DEF,
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  parameter int unsigned MIN_GAP      = MIN_GAP_DEF
) (
  input  logic             CLK,
  input  logic             RST_SYS,
  input  logic             EN,
  input  logic             TRIG_REQ,
  input  logic             PERIODIC_EN,
  input  logic [31:0]      PERIOD,
  input  logic             BUSY_IN,
  input  logic             TRIGGER_CLOCK_IN,
  output logic             TRIGGER_OUT,
  output logic [NBITS-1:0] TRIGGER_CNT,
  output logic             TRIGGER_SENT,
  output logic             TIMEOUT_ERR,
  output logic             SHORT_ERR,
  output logic             REQ_DROPPED,
  output logic [15:0]      DROPPED_CNT,
  output logic             IDLE
);

  localparam int unsigned IDX_W = $clog2(NBITS + 1);

  // Timer values on which the timed states leave; timer is 0 on state entry,
  // so a state lasts LAST+1 cycles.
  localparam logic [31:0] BUSY_LAST = (BUSY_TIMEOUT == 0) ? 32'd0 : 32'(BUSY_TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST  = (MIN_GAP == 0) ? 32'd0 : 32'(MIN_GAP - 1);

  // ---------------------------------------------------------------------------
  // Asynchronous input synchronizers
  // ---------------------------------------------------------------------------
  logic busy_s, busy_rise_unused, busy_fall_unused;
  logic tclk_level_unused, tclk_rise_unused, tclk_fall;

  tlu_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_busy (
    .clk   (CLK),
    .rst   (RST_SYS),
    .din   (BUSY_IN),
    .level (busy_s),
    .rise  (busy_rise_unused),
    .fall  (busy_fall_unused)
  );

  tlu_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_tclk (
    .clk   (CLK),
    .rst   (RST_SYS),
    .din   (TRIGGER_CLOCK_IN),
    .level (tclk_level_unused),
    .rise  (tclk_rise_unused),
    .fall  (tclk_fall)
  );

  // ---------------------------------------------------------------------------
  // Periodic trigger generator and request merge
  // ---------------------------------------------------------------------------
  logic [31:0] per_cnt_q;
  logic [31:0] period_eff;
  logic        per_run;
  logic        tick;
  logic        req;

  assign period_eff = (PERIOD < 32'd2) ? 32'd2 : PERIOD;
  assign per_run    = EN & PERIODIC_EN;
  // ">=" so that shrinking PERIOD mid-count fires at once instead of wrapping.
  assign tick       = per_run && (per_cnt_q >= period_eff - 32'd1);
  assign req        = EN & (TRIG_REQ | tick);

  always_ff @(posedge CLK) begin
    if (RST_SYS || !per_run) begin
      per_cnt_q <= 32'd0;
    end else if (tick) begin
      per_cnt_q <= 32'd0;
    end else begin
      per_cnt_q <= per_cnt_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM, shift register, timer and counters
  // ---------------------------------------------------------------------------
  tlu_state_e       state_q;
  logic [NBITS-1:0] cnt_q;
  logic [NBITS-1:0] cnt_nxt;
  logic [NBITS-1:0] shift_q;
  logic [NBITS-1:0] shift_nxt;
  logic [IDX_W-1:0] bit_idx_q;
  logic [31:0]      timer_q;

  assign cnt_nxt     = cnt_q + NBITS'(1);
  assign shift_nxt   = shift_q >> 1;
  assign TRIGGER_CNT = cnt_q;

  always_ff @(posedge CLK) begin
    if (RST_SYS) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      timer_q      <= 32'd0;
      TRIGGER_OUT  <= 1'b0;
      TRIGGER_SENT <= 1'b0;
      TIMEOUT_ERR  <= 1'b0;
      SHORT_ERR    <= 1'b0;
      REQ_DROPPED  <= 1'b0;
      DROPPED_CNT  <= 16'd0;
      IDLE         <= 1'b1;
    end else begin
      TRIGGER_SENT <= 1'b0;
      TIMEOUT_ERR  <= 1'b0;
      SHORT_ERR    <= 1'b0;
      REQ_DROPPED  <= 1'b0;
      timer_q      <= sat_inc32(timer_q);

      if (req && (state_q != ST_IDLE)) begin
        REQ_DROPPED <= 1'b1;
        if (DROPPED_CNT != 16'hFFFF) begin
          DROPPED_CNT <= DROPPED_CNT + 16'd1;
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          TRIGGER_OUT <= 1'b0;
          if (req) begin
            cnt_q       <= cnt_nxt;
            shift_q     <= cnt_nxt;
            TRIGGER_OUT <= 1'b1;
            timer_q     <= 32'd0;
            IDLE        <= 1'b0;
            state_q     <= ST_ASSERT;
          end
        end

        ST_ASSERT: begin
          TRIGGER_OUT <= 1'b1;
          if (busy_s) begin
            TRIGGER_OUT <= shift_q[0];
            bit_idx_q   <= '0;
            timer_q     <= 32'd0;
            state_q     <= ST_SHIFT;
          end else if (timer_q >= BUSY_LAST) begin
            // The number is consumed; the next trigger carries the following one.
            TIMEOUT_ERR <= 1'b1;
            TRIGGER_OUT <= 1'b0;
            timer_q     <= 32'd0;
            state_q     <= ST_GAP;
          end
        end

        ST_SHIFT: begin
          // Data changes only after the DUT has sampled on a falling edge.
          if (tclk_fall) begin
            if (bit_idx_q == IDX_W'(NBITS - 1)) begin
              TRIGGER_OUT <= 1'b0;
              timer_q     <= 32'd0;
              state_q     <= ST_RELEASE;
            end else begin
              bit_idx_q   <= bit_idx_q + IDX_W'(1);
              shift_q     <= shift_nxt;
              TRIGGER_OUT <= shift_nxt[0];
            end
          end else if (!busy_s) begin
            SHORT_ERR   <= 1'b1;
            TRIGGER_OUT <= 1'b0;
            timer_q     <= 32'd0;
            state_q     <= ST_GAP;
          end
        end

        ST_RELEASE: begin
          TRIGGER_OUT <= 1'b0;
          if (!busy_s) begin
            TRIGGER_SENT <= 1'b1;
            timer_q      <= 32'd0;
            state_q      <= ST_GAP;
          end else if (timer_q >= BUSY_LAST) begin
            TIMEOUT_ERR <= 1'b1;
            timer_q     <= 32'd0;
            state_q     <= ST_GAP;
          end
        end

        ST_GAP: begin
          TRIGGER_OUT <= 1'b0;
          if (timer_q >= GAP_LAST) begin
            IDLE    <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          TRIGGER_OUT <= 1'b0;
          IDLE        <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlu_emulator.sv
// Directed bench for tlu_emulator with a behavioural DUT-side handshake model.
// Expected trigger numbers are queued when a trigger is requested and popped
// when the model has clocked in a complete number.
module tb_tlu_emulator;

  localparam int unsigned NB  = 8;
  localparam int unsigned BT  = 4096;
  localparam int unsigned GAP = 16;
  localparam int unsigned SS  = 2;

  logic          CLK = 1'b0;
  logic          RST_SYS;
  logic          EN;
  logic          TRIG_REQ;
  logic          PERIODIC_EN;
  logic [31:0]   PERIOD;
  logic          BUSY_IN;
  logic          TRIGGER_CLOCK_IN;
  logic          TRIGGER_OUT;
  logic [NB-1:0] TRIGGER_CNT;
  logic          TRIGGER_SENT;
  logic          TIMEOUT_ERR;
  logic          SHORT_ERR;
  logic          REQ_DROPPED;
  logic [15:0]   DROPPED_CNT;
  logic          IDLE;

  tlu_emulator #(
    .NBITS        (NB),
    .SYNC_STAGES  (SS),
    .BUSY_TIMEOUT (BT),
    .MIN_GAP      (GAP)
  ) dut (
    .CLK              (CLK),
    .RST_SYS          (RST_SYS),
    .EN               (EN),
    .TRIG_REQ         (TRIG_REQ),
    .PERIODIC_EN      (PERIODIC_EN),
    .PERIOD           (PERIOD),
    .BUSY_IN          (BUSY_IN),
    .TRIGGER_CLOCK_IN (TRIGGER_CLOCK_IN),
    .TRIGGER_OUT      (TRIGGER_OUT),
    .TRIGGER_CNT      (TRIGGER_CNT),
    .TRIGGER_SENT     (TRIGGER_SENT),
    .TIMEOUT_ERR      (TIMEOUT_ERR),
    .SHORT_ERR        (SHORT_ERR),
    .REQ_DROPPED      (REQ_DROPPED),
    .DROPPED_CNT      (DROPPED_CNT),
    .IDLE             (IDLE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected trigger numbers.
  logic [NB-1:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Monitor: pulse counters and timing, sampled on the falling clock edge
  // ---------------------------------------------------------------------------
  int n_sent = 0, n_tmo = 0, n_short = 0, n_drop = 0, n_start = 0;
  int cyc = 0, last_start = 0, hi_run = 0, last_hi = 0, low_run = 0, last_gap = 0;
  logic prev_idle = 1'b1;
  logic short_tout = 1'b1;

  always @(negedge CLK) begin
    cyc++;
    if (TRIGGER_SENT === 1'b1) n_sent++;
    if (TIMEOUT_ERR === 1'b1) n_tmo++;
    if (REQ_DROPPED === 1'b1) n_drop++;
    if (SHORT_ERR === 1'b1) begin
      n_short++;
      short_tout = TRIGGER_OUT;
    end
    if (prev_idle && IDLE === 1'b0) begin
      n_start++;
      last_start = cyc;
    end
    prev_idle = (IDLE === 1'b1);
    if (TRIGGER_OUT === 1'b1) begin
      hi_run++;
      low_run = 0;
    end else begin
      if (hi_run != 0) last_hi = hi_run;
      hi_run = 0;
      if (IDLE === 1'b0) low_run++;
      else if (low_run != 0) begin
        last_gap = low_run;
        low_run  = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // DUT-side handshake model: trigger clock = 8 CLK periods
  // ---------------------------------------------------------------------------
  logic          model_on = 1'b0;
  logic          model_quiet = 1'b0;
  logic          model_active = 1'b0;
  int            short_after = 0;
  int            model_falls = 0;
  logic [NB-1:0] rx;
  logic [NB-1:0] rx_exp;

  task automatic mtick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin : dut_model
    BUSY_IN          = 1'b0;
    TRIGGER_CLOCK_IN = 1'b0;
    forever begin
      mtick(1);
      if (model_on && TRIGGER_OUT === 1'b1) begin
        model_active = 1'b1;
        model_falls  = 0;
        rx           = '0;
        mtick(3);
        BUSY_IN = 1'b1;
        mtick(8);
        for (int b = 0; b < int'(NB); b++) begin
          TRIGGER_CLOCK_IN = 1'b1;
          mtick(4);
          TRIGGER_CLOCK_IN = 1'b0;
          rx[b] = TRIGGER_OUT;
          model_falls++;
          mtick(4);
          if (model_falls == short_after) break;
        end
        mtick(2);
        BUSY_IN = 1'b0;
        if (model_falls == int'(NB) && !model_quiet) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_trigger", 32'd0, 32'd1);
          end else begin
            rx_exp = exp_q.pop_front();
            check("rx_number", 32'(rx), 32'(rx_exp));
          end
        end
        model_active = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic pulse_req();
    @(negedge CLK);
    TRIG_REQ = 1'b1;
    @(negedge CLK);
    TRIG_REQ = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    repeat (3) @(negedge CLK);
    n = 0;
    while (IDLE !== 1'b1 && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(IDLE), 32'd1);
    @(negedge CLK);
  endtask

  task automatic loop_trigger(input logic [NB-1:0] num, input string tag);
    exp_q.push_back(num);
    pulse_req();
    wait_idle(tag);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int s_sent, s_tmo, s_short, s_drop, s_start, n, t1, t2, t3;

  initial begin : stim
    RST_SYS     = 1'b1;
    EN          = 1'b0;
    TRIG_REQ    = 1'b0;
    PERIODIC_EN = 1'b0;
    PERIOD      = 32'd0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_trigger_out", 32'(TRIGGER_OUT), 32'd0);
    check("rst_idle", 32'(IDLE), 32'd1);
    check("rst_trigger_cnt", 32'(TRIGGER_CNT), 32'd0);
    check("rst_dropped_cnt", 32'(DROPPED_CNT), 32'd0);
    check("rst_pulses", {28'd0, TRIGGER_SENT, TIMEOUT_ERR, SHORT_ERR, REQ_DROPPED}, 32'd0);
    RST_SYS = 1'b0;
    EN      = 1'b1;
    @(negedge CLK);

    // Loopback: three requests carry 1, 2, 3
    model_on = 1'b1;
    s_sent = n_sent; s_tmo = n_tmo; s_short = n_short;
    for (int k = 1; k <= 3; k++) loop_trigger(NB'(k), "loop_idle");
    check("loop_cnt", 32'(TRIGGER_CNT), 32'd3);
    check("loop_sent", 32'(n_sent - s_sent), 32'd3);
    check("loop_errs", 32'((n_tmo - s_tmo) + (n_short - s_short)), 32'd0);
    check("loop_sb_empty", 32'(exp_q.size()), 32'd0);

    // BUSY never rises: line high for the timeout, then held low for the gap
    model_on = 1'b0;
    s_sent = n_sent; s_tmo = n_tmo;
    pulse_req();
    wait_idle("tmo_idle");
    check("tmo_high_cycles", 32'(last_hi), 32'(BT));
    check("tmo_gap_cycles", 32'(last_gap), 32'(GAP));
    check("tmo_err_pulse", 32'(n_tmo - s_tmo), 32'd1);
    check("tmo_no_sent", 32'(n_sent - s_sent), 32'd0);
    check("tmo_cnt", 32'(TRIGGER_CNT), 32'd4);
    model_on = 1'b1;
    loop_trigger(NB'(5), "after_tmo_idle");

    // BUSY dropped after five bits
    s_sent = n_sent; s_short = n_short;
    short_after = 5;
    pulse_req();
    wait_idle("short_idle");
    short_after = 0;
    check("short_err_pulse", 32'(n_short - s_short), 32'd1);
    check("short_no_sent", 32'(n_sent - s_sent), 32'd0);
    check("short_line_low", 32'(short_tout), 32'd0);
    check("short_cnt", 32'(TRIGGER_CNT), 32'd6);

    // Request during an active handshake is dropped
    s_drop = n_drop; s_start = n_start;
    exp_q.push_back(NB'(7));
    pulse_req();
    repeat (20) @(negedge CLK);
    pulse_req();
    wait_idle("drop_idle");
    check("drop_pulse", 32'(n_drop - s_drop), 32'd1);
    check("drop_cnt", 32'(DROPPED_CNT), 32'd1);
    check("drop_one_start", 32'(n_start - s_start), 32'd1);
    check("drop_trig_cnt", 32'(TRIGGER_CNT), 32'd7);

    // Periodic triggers every PERIOD cycles
    PERIOD = 32'd600;
    for (int k = 8; k <= 10; k++) exp_q.push_back(NB'(k));
    s_start = n_start;
    PERIODIC_EN = 1'b1;
    t1 = 0; t2 = 0; t3 = 0;
    for (int j = 1; j <= 3; j++) begin
      n = 0;
      while (n_start < s_start + j && n < 2000) begin
        @(negedge CLK);
        n++;
      end
      check("per_started", 32'(n_start - s_start >= j), 32'd1);
      if (j == 1) t1 = last_start;
      if (j == 2) t2 = last_start;
      if (j == 3) t3 = last_start;
    end
    PERIODIC_EN = 1'b0;
    wait_idle("per_idle");
    check("per_interval_1", 32'(t2 - t1), 32'd600);
    check("per_interval_2", 32'(t3 - t2), 32'd600);
    check("per_cnt", 32'(TRIGGER_CNT), 32'd10);

    // Run the counter up to its maximum; the next trigger wraps to 0
    for (int k = 11; k <= (1 << NB); k++) loop_trigger(NB'(k), "wrap_idle");
    check("wrap_cnt", 32'(TRIGGER_CNT), 32'd0);
    check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset during the shift phase
    model_quiet = 1'b1;
    pulse_req();
    n = 0;
    while (model_falls < 3 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("rst_mid_in_shift", 32'(model_falls >= 3), 32'd1);
    RST_SYS = 1'b1;
    @(negedge CLK);
    check("rst_mid_trigger_out", 32'(TRIGGER_OUT), 32'd0);
    check("rst_mid_idle", 32'(IDLE), 32'd1);
    check("rst_mid_cnt", 32'(TRIGGER_CNT), 32'd0);
    n = 0;
    while (model_active && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    RST_SYS = 1'b0;
    repeat (4) @(negedge CLK);
    model_quiet = 1'b0;
    loop_trigger(NB'(1), "post_rst_idle");
    check("post_rst_cnt", 32'(TRIGGER_CNT), 32'd1);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
